// File: rtl/reset_sequencer.sv
`default_nettype none
// reset_sequencer: releases three subsystem resets in order 0,1,2, waiting for each Ack before the next.
// Optional Ack timeout compiled in with macro RESET_SEQ_TIMEOUT_EN.
module reset_sequencer #(
  parameter int unsigned STAGE_DELAY = 1000,
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned DELAY_W     = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] Ack,
  output logic [2:0] StageReset,
  output logic       Done,
  output logic       Fault,
  output logic [1:0] Stage
);

  localparam longint unsigned MAX_CNT    = (64'd1 << DELAY_W) - 64'd1;
  localparam logic [DELAY_W-1:0] CNT_ONE    = DELAY_W'(1);
  localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'(STAGE_DELAY - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [DELAY_W-1:0] TOUT_LAST  = DELAY_W'(TIMEOUT - 1);
`endif

  // Elaboration-time guard on the legal parameter ranges.
  if (STAGE_DELAY < 1 || 64'(STAGE_DELAY) > MAX_CNT) begin : g_bad_stage_delay
    $error("reset_sequencer: STAGE_DELAY out of range");
  end
  if (TIMEOUT < 1 || 64'(TIMEOUT) > MAX_CNT) begin : g_bad_timeout
    $error("reset_sequencer: TIMEOUT out of range");
  end

  typedef enum logic [1:0] {
    S_DELAY = 2'd0,
    S_ACK   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         stage_q, stage_d;
  logic [DELAY_W-1:0] cnt_q,   cnt_d;
  logic [2:0]         srst_q,  srst_d;
  logic               done_q,  done_d;
  logic               fault_q, fault_d;

  logic               ack_cur;
  logic [2:0]         rel_mask;

  // Only the Ack bit of the stage being sequenced matters.
  assign ack_cur  = (stage_q == 2'd0) ? Ack[0] :
                    (stage_q == 2'd1) ? Ack[1] : Ack[2];
  assign rel_mask = 3'b001 << stage_q;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    srst_d  = srst_q;
    done_d  = done_q;
    fault_d = fault_q;
    case (state_q)
      S_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          srst_d  = srst_q & ~rel_mask;
          cnt_d   = '0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ACK: begin
        if (ack_cur) begin
          cnt_d = '0;
          if (stage_q == 2'd2) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            stage_d = 2'd3;
          end else begin
            state_d = S_DELAY;
            stage_d = stage_q + 2'd1;
          end
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (cnt_q == TOUT_LAST) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          srst_d  = 3'b111;
        end
`endif
        else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        // Any subsystem dropping its ready flag re-runs the whole sequence.
        if (Ack != 3'b111) begin
          state_d = S_DELAY;
          stage_d = 2'd0;
          cnt_d   = '0;
          srst_d  = 3'b111;
          done_d  = 1'b0;
        end
      end
      S_FAULT: begin
        srst_d = 3'b111;
        done_d = 1'b0;
      end
      default: state_d = S_DELAY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_DELAY;
      stage_q <= 2'd0;
      cnt_q   <= '0;
      srst_q  <= 3'b111;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      srst_q  <= srst_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign StageReset = srst_q;
  assign Done       = done_q;
  assign Fault      = fault_q;
  assign Stage      = stage_q;

endmodule
`default_nettype wire
